// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM GF(2^128) multiplier.
// Blocks use GCM bit order: index 0 is the most significant bit.
package gcm_pkg;

    typedef logic [0:127] block_t;

    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in reflected bit order
    localparam block_t GF_R = {8'hE1, 120'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One step of V: multiply by x and reduce.
    function automatic block_t gf_mul_x(input block_t v);
        return (v >> 1) ^ (v[127] ? GF_R : '0);
    endfunction

endpackage

// File: rtl/gf128_mul_serial_if.sv
// Operand/result handshake bundle for gf128_mul_serial.
interface gf128_mul_serial_if;
    import gcm_pkg::*;

    logic   iValid;
    logic   oReady;
    block_t iData;
    block_t iHashkey;
    logic   iAccum;
    logic   iClear;
    logic   oValid;
    logic   iReady;
    block_t oResult;

    modport master (
        output iValid, iData, iHashkey, iAccum, iClear, iReady,
        input  oReady, oValid, oResult
    );

    modport slave (
        input  iValid, iData, iHashkey, iAccum, iClear, iReady,
        output oReady, oValid, oResult
    );

endinterface

// File: rtl/gf128_digit_step.sv
// Combinational digit step: consumes DIGIT_W multiplier bits, bit 0 first,
// updating the partial product Z and the shifted multiplicand V.
module gf128_digit_step
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic [0:DIGIT_W-1] a_digit,
    input  block_t             z_in,
    input  block_t             v_in,
    output block_t             z_out,
    output block_t             v_out
);

    block_t z_acc;
    block_t v_acc;

    always_comb begin
        z_acc = z_in;
        v_acc = v_in;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (a_digit[i]) begin
                z_acc = z_acc ^ v_acc;
            end
            v_acc = gf_mul_x(v_acc);
        end
    end

    assign z_out = z_acc;
    assign v_out = v_acc;

endmodule

// File: rtl/gf128_mul_serial.sv
// Digit-serial GF(2^128) multiplier with a GHASH accumulator Y.
// One multiplication takes 128/DIGIT_W cycles; iClear aborts and zeroes Y.
module gf128_mul_serial
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input logic                iClk,
    input logic                iRstn,
    gf128_mul_serial_if.slave  bus
);

    localparam int NCYC  = 128 / DIGIT_W;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

    state_t           state_q, state_d;
    block_t           a_q, a_d;
    block_t           z_q, z_d;
    block_t           v_q, v_d;
    block_t           y_q, y_d;
    block_t           result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    block_t z_step;
    block_t v_step;

    gf128_digit_step #(
        .DIGIT_W (DIGIT_W)
    ) u_step (
        .a_digit (a_q[0:DIGIT_W-1]),
        .z_in    (z_q),
        .v_in    (v_q),
        .z_out   (z_step),
        .v_out   (v_step)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        z_d      = z_q;
        v_d      = v_q;
        y_d      = y_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        if (bus.iClear) begin
            state_d  = IDLE;
            y_d      = '0;
            result_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iValid) begin
                        a_d     = bus.iAccum ? (y_q ^ bus.iData) : bus.iData;
                        v_d     = bus.iHashkey;
                        z_d     = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    // The consumed digit is shifted out so the next one sits at bit 0
                    a_d = a_q << DIGIT_W;
                    z_d = z_step;
                    v_d = v_step;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        result_d = z_step;
                        y_d      = z_step;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.iReady) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            z_q      <= '0;
            v_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            z_q      <= z_d;
            v_q      <= v_d;
            y_q      <= y_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.oReady  = (state_q == IDLE);
    assign bus.oValid  = (state_q == DONE);
    assign bus.oResult = result_q;

endmodule

// File: tb/tb_gf128_mul_serial.sv
// Drives three multipliers (DIGIT_W = 1, 8, 128) in lockstep and checks each
// against published GCM vectors and a polynomial-multiply reference.
module tb_gf128_mul_serial;

    localparam int WID_TAB  [3] = '{1, 8, 128};
    localparam int NCYC_TAB [3] = '{128, 16, 1};

    localparam logic [0:127] H_K  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] C_K  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [0:127] X1_K = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [0:127] LEN  = 128'h00000000000000000000000000000080;
    localparam logic [0:127] GH_K = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [0:127] ONE  = 128'h80000000000000000000000000000000;

    logic clk;
    logic rstn;
    logic valid, accum, clear, ready;
    logic [0:127] data, hkey;

    int n_checks;
    int n_fail;

    gf128_mul_serial_if bus1 ();
    gf128_mul_serial_if bus8 ();
    gf128_mul_serial_if bus128 ();

    assign bus1.iValid   = valid;  assign bus8.iValid   = valid;  assign bus128.iValid   = valid;
    assign bus1.iData    = data;   assign bus8.iData    = data;   assign bus128.iData    = data;
    assign bus1.iHashkey = hkey;   assign bus8.iHashkey = hkey;   assign bus128.iHashkey = hkey;
    assign bus1.iAccum   = accum;  assign bus8.iAccum   = accum;  assign bus128.iAccum   = accum;
    assign bus1.iClear   = clear;  assign bus8.iClear   = clear;  assign bus128.iClear   = clear;
    assign bus1.iReady   = ready;  assign bus8.iReady   = ready;  assign bus128.iReady   = ready;

    gf128_mul_serial #(.DIGIT_W(1))   dut1   (.iClk(clk), .iRstn(rstn), .bus(bus1));
    gf128_mul_serial #(.DIGIT_W(8))   dut8   (.iClk(clk), .iRstn(rstn), .bus(bus8));
    gf128_mul_serial #(.DIGIT_W(128)) dut128 (.iClk(clk), .iRstn(rstn), .bus(bus128));

    logic [0:127] res [3];
    logic         vld [3];
    logic         rdy [3];

    assign res[0] = bus1.oResult;  assign vld[0] = bus1.oValid;  assign rdy[0] = bus1.oReady;
    assign res[1] = bus8.oResult;  assign vld[1] = bus8.oValid;  assign rdy[1] = bus8.oReady;
    assign res[2] = bus128.oResult; assign vld[2] = bus128.oValid; assign rdy[2] = bus128.oReady;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Schoolbook carry-less product followed by reduction modulo x^128+x^7+x^2+x+1
    function automatic logic [0:127] ref_mul(input logic [0:127] a, input logic [0:127] b);
        logic [0:254] p;
        p = '0;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++)
                if (a[i] && b[j]) p[i+j] = ~p[i+j];
        for (int k = 254; k >= 128; k--) begin
            if (p[k]) begin
                p[k]     = 1'b0;
                p[k-128] = ~p[k-128];
                p[k-127] = ~p[k-127];
                p[k-126] = ~p[k-126];
                p[k-121] = ~p[k-121];
            end
        end
        return p[0:127];
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pop_result(input string name);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (vld[k] !== 1'b0 || rdy[k] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL %s w=%0d after-pop got valid=%b ready=%b expected 0/1",
                         name, WID_TAB[k], vld[k], rdy[k]);
            end
        end
    endtask

    task automatic run_op(input logic [0:127] x, input logic [0:127] h, input logic acc,
                          input logic [0:127] expv, input string name, input bit pop);
        int lat [3];
        bit seen [3];
        for (int k = 0; k < 3; k++) begin
            lat[k]  = 0;
            seen[k] = 1'b0;
        end
        @(negedge clk);
        data = x; hkey = h; accum = acc; valid = 1'b1; ready = 1'b0;
        @(negedge clk);
        valid = 1'b0; data = ~x; hkey = ~h;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b0 || vld[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL %s w=%0d busy-flags got ready=%b valid=%b expected 0/0",
                         name, WID_TAB[k], rdy[k], vld[k]);
            end
        end
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (!seen[k] && vld[k] === 1'b1) begin
                    seen[k] = 1'b1;
                    lat[k]  = c;
                end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (lat[k] != NCYC_TAB[k]) begin
                n_fail++;
                $display("[TB] FAIL %s w=%0d latency got %0d expected %0d",
                         name, WID_TAB[k], lat[k], NCYC_TAB[k]);
            end
            n_checks++;
            if (res[k] !== expv) begin
                n_fail++;
                $display("[TB] FAIL %s w=%0d result got %h expected %h",
                         name, WID_TAB[k], res[k], expv);
            end
        end
        if (pop) pop_result(name);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        valid = 1'b0; accum = 1'b0; clear = 1'b0; ready = 1'b0;
        data = '0; hkey = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (vld[k] !== 1'b0 || res[k] !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset w=%0d got valid=%b result=%h expected 0/0",
                         WID_TAB[k], vld[k], res[k]);
            end
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b1 || vld[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset-release w=%0d got ready=%b valid=%b expected 1/0",
                         WID_TAB[k], rdy[k], vld[k]);
            end
        end
    endtask

    task automatic test_known_vector();
        run_op(C_K, H_K, 1'b0, X1_K, "gcm_tc2", 1'b1);
    endtask

    task automatic test_identity();
        run_op(ONE, H_K, 1'b0, H_K, "x_one", 1'b1);
        run_op('0, H_K, 1'b0, '0, "x_zero", 1'b1);
        run_op(C_K, ONE, 1'b0, C_K, "h_one", 1'b1);
    endtask

    task automatic test_ghash_chain();
        run_op(C_K, H_K, 1'b0, X1_K, "chain_x1", 1'b1);
        run_op(LEN, H_K, 1'b1, GH_K, "chain_len", 1'b1);
        clear_pulse();
        run_op(C_K, H_K, 1'b1, X1_K, "chain_cleared", 1'b1);
    endtask

    task automatic test_stall();
        run_op(ONE, H_K, 1'b0, H_K, "stall", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid = (i % 2 == 0);
            data  = rand128();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (vld[k] !== 1'b1 || rdy[k] !== 1'b0 || res[k] !== H_K) begin
                    n_fail++;
                    $display("[TB] FAIL stall w=%0d cyc=%0d got valid=%b ready=%b result=%h expected 1/0/%h",
                             WID_TAB[k], i, vld[k], rdy[k], res[k], H_K);
                end
            end
        end
        @(negedge clk);
        valid = 1'b0;
        pop_result("stall");
    endtask

    task automatic test_clear_in_done();
        run_op(C_K, H_K, 1'b0, X1_K, "clear_done", 1'b0);
        @(negedge clk);
        clear = 1'b1; ready = 1'b1; valid = 1'b1; data = LEN; hkey = H_K;
        @(negedge clk);
        clear = 1'b0; ready = 1'b0; valid = 1'b0;
        repeat (2) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (vld[k] !== 1'b0 || rdy[k] !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL clear_done w=%0d got valid=%b ready=%b expected 0/1",
                             WID_TAB[k], vld[k], rdy[k]);
                end
            end
            @(negedge clk);
        end
        run_op(C_K, H_K, 1'b1, X1_K, "after_clear", 1'b1);
    endtask

    task automatic test_reset_mid_busy();
        bit pulsed [3];
        run_op(C_K, H_K, 1'b0, X1_K, "pre_reset", 1'b1);
        @(negedge clk);
        data = LEN; hkey = H_K; accum = 1'b1; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (vld[k] !== 1'b0 || rdy[k] !== 1'b1 || res[k] !== '0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset w=%0d got valid=%b ready=%b result=%h expected 0/1/0",
                         WID_TAB[k], vld[k], rdy[k], res[k]);
            end
            pulsed[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (vld[k] !== 1'b0) pulsed[k] = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (pulsed[k]) begin
                n_fail++;
                $display("[TB] FAIL post_reset_pulse w=%0d got a valid pulse expected none",
                         WID_TAB[k]);
            end
        end
        run_op(C_K, H_K, 1'b1, X1_K, "after_reset", 1'b1);
    endtask

    task automatic test_random();
        logic [0:127] y_model, x, h, expv;
        logic acc;
        clear_pulse();
        y_model = '0;
        for (int n = 0; n < 20; n++) begin
            x    = rand128();
            h    = rand128();
            acc  = 1'($urandom_range(0, 1));
            expv = ref_mul(acc ? (y_model ^ x) : x, h);
            y_model = expv;
            run_op(x, h, acc, expv, "random", 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pop_result("random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_known_vector();
        test_identity();
        test_ghash_chain();
        test_stall();
        test_clear_in_done();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
